// File: rtl/falafel_mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single falafel memory port and routes
// in-order memory responses back to the issuer through a tag FIFO.

module falafel_mem_arbiter_lane (
  input  logic grant,
  input  logic head,
  input  logic req_go,
  input  logic resp_val,
  output logic req_rdy,
  output logic rsp_val
);
  assign req_rdy = grant & req_go;
  assign rsp_val = head & resp_val;
endmodule

module falafel_mem_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_val_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  input  logic [NUM_REQ-1:0]             req_is_write_i,
  input  logic [NUM_REQ-1:0]             req_is_cas_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_cas_exp_i,
  output logic [NUM_REQ-1:0]             rsp_val_o,
  input  logic [NUM_REQ-1:0]             rsp_rdy_i,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic                           mem_req_val_o,
  input  logic                           mem_req_rdy_i,
  output logic                           mem_req_is_write_o,
  output logic                           mem_req_is_cas_o,
  output logic [DATA_W-1:0]              mem_req_addr_o,
  output logic [DATA_W-1:0]              mem_req_data_o,
  output logic [DATA_W-1:0]              mem_req_cas_exp_o,
  input  logic                           mem_resp_val_i,
  output logic                           mem_resp_rdy_o,
  input  logic [DATA_W-1:0]              mem_resp_data_i
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic              is_write;
    logic              is_cas;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] cas_exp;
  } mem_req_t;

  typedef enum logic {IDLE, LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_idx, grant_idx;
  logic             rr_vld, grant_vld;
  logic [IDX_W:0]   cand;

  logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             tag_full, tag_empty, push, pop;
  logic [IDX_W-1:0] head;

  mem_req_t         req_sel;

  assign tag_full  = (count_q == FULL);
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem[rd_ptr_q];

  // Rotating priority: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!rr_vld && req_val_i[cand[IDX_W-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Once granted, a requester keeps the port until its handshake so the
  // presented request fields cannot be swapped under a stalled memory.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    grant_idx  = rr_idx;
    grant_vld  = rr_vld;
    if (state_q == LOCKED) begin
      grant_idx = lock_idx_q;
      grant_vld = 1'b1;
    end
    case (state_q)
      IDLE: if (grant_vld && !push) begin
        state_d    = LOCKED;
        lock_idx_d = grant_idx;
      end
      LOCKED: if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_sel = '{is_write: req_is_write_i[grant_idx],
                     is_cas:   req_is_cas_i[grant_idx],
                     addr:     req_addr_i[grant_idx],
                     data:     req_data_i[grant_idx],
                     cas_exp:  req_cas_exp_i[grant_idx]};

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign mem_req_val_o      = rst_ni & grant_vld & req_val_i[grant_idx] & ~tag_full;
  assign mem_req_is_write_o = rst_ni & req_sel.is_write;
  assign mem_req_is_cas_o   = rst_ni & req_sel.is_cas;
  assign mem_req_addr_o     = rst_ni ? req_sel.addr    : '0;
  assign mem_req_data_o     = rst_ni ? req_sel.data    : '0;
  assign mem_req_cas_exp_o  = rst_ni ? req_sel.cas_exp : '0;
  assign mem_resp_rdy_o     = rst_ni & ~tag_empty & rsp_rdy_i[head];
  assign rsp_data_o         = rst_ni ? mem_resp_data_i : '0;

  assign push = mem_req_val_o & mem_req_rdy_i;
  assign pop  = mem_resp_val_i & mem_resp_rdy_o;

  for (genvar l = 0; l < NUM_REQ; l++) begin : g_lane
    falafel_mem_arbiter_lane u_lane (
      .grant    (grant_vld && (grant_idx == IDX_W'(l))),
      .head     (!tag_empty && (head == IDX_W'(l))),
      .req_go   (rst_ni & mem_req_rdy_i & ~tag_full),
      .resp_val (rst_ni & mem_resp_val_i),
      .req_rdy  (req_rdy_o[l]),
      .rsp_val  (rsp_val_o[l])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      if (push)
        rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Randomized bench for falafel_mem_arbiter against a queue-based model of the
// grant/lock/tag rules, plus directed single-read and mid-operation reset.

module tb_falafel_mem_arbiter;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int MO = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_val, req_rdy, req_is_write, req_is_cas;
  logic [N-1:0][DW-1:0]   req_addr, req_data, req_cas_exp;
  logic [N-1:0]           rsp_val, rsp_rdy;
  logic [DW-1:0]          rsp_data;
  logic                   mem_req_val, mem_req_rdy, mem_req_is_write, mem_req_is_cas;
  logic [DW-1:0]          mem_req_addr, mem_req_data, mem_req_cas_exp;
  logic                   mem_resp_val, mem_resp_rdy;
  logic [DW-1:0]          mem_resp_data;

  falafel_mem_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_val_i(req_val), .req_rdy_o(req_rdy),
    .req_is_write_i(req_is_write), .req_is_cas_i(req_is_cas),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_cas_exp_i(req_cas_exp),
    .rsp_val_o(rsp_val), .rsp_rdy_i(rsp_rdy), .rsp_data_o(rsp_data),
    .mem_req_val_o(mem_req_val), .mem_req_rdy_i(mem_req_rdy),
    .mem_req_is_write_o(mem_req_is_write), .mem_req_is_cas_o(mem_req_is_cas),
    .mem_req_addr_o(mem_req_addr), .mem_req_data_o(mem_req_data),
    .mem_req_cas_exp_o(mem_req_cas_exp),
    .mem_resp_val_i(mem_resp_val), .mem_resp_rdy_o(mem_resp_rdy),
    .mem_resp_data_i(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int     tagq[$];
  bit     locked;
  int     lidx;
  int     rr;
  bit [N-1:0] acc_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    tagq.delete();
    locked   = 1'b0;
    lidx     = 0;
    rr       = 0;
    acc_mask = '0;
  endtask

  // Open a cycle: accepted requests from the previous edge drop their valid.
  task automatic begin_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (acc_mask[i]) req_val[i] = 1'b0;
    acc_mask = '0;
  endtask

  // Check combinational outputs for the current inputs, then advance the model
  // to what the coming clock edge must do.
  task automatic eval_cycle();
    bit gv, full, empty, e_mval, e_mrr;
    int g, head;
    logic [63:0] e_rdy, e_rval;
    #1;
    gv = 1'b0; g = 0;
    if (locked) begin gv = 1'b1; g = lidx; end
    else for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (!gv && req_val[idx]) begin gv = 1'b1; g = idx; end
    end
    full  = (tagq.size() == MO);
    empty = (tagq.size() == 0);
    head  = empty ? 0 : tagq[0];
    e_mval = gv && req_val[g] && !full;
    e_rdy  = (gv && mem_req_rdy && !full) ? (64'd1 << g) : 64'd0;
    e_rval = (!empty && mem_resp_val) ? (64'd1 << head) : 64'd0;
    e_mrr  = !empty && rsp_rdy[head];
    chk("mem_req_val", 64'(mem_req_val), 64'(e_mval));
    chk("req_rdy", 64'(req_rdy), e_rdy);
    if (gv) begin
      chk("mem_req_addr", mem_req_addr, req_addr[g]);
      chk("mem_req_data", mem_req_data, req_data[g]);
      chk("mem_req_cas_exp", mem_req_cas_exp, req_cas_exp[g]);
      chk("mem_req_ctl", {62'd0, mem_req_is_write, mem_req_is_cas},
          {62'd0, req_is_write[g], req_is_cas[g]});
    end
    chk("rsp_val", 64'(rsp_val), e_rval);
    chk("mem_resp_rdy", 64'(mem_resp_rdy), 64'(e_mrr));
    chk("rsp_data", rsp_data, mem_resp_data);
    if (mem_resp_val && e_mrr) void'(tagq.pop_front());
    if (e_mval && mem_req_rdy) begin
      tagq.push_back(g);
      locked = 1'b0;
      rr = (g + 1) % N;
      acc_mask[g] = 1'b1;
    end else if (gv) begin
      locked = 1'b1;
      lidx = g;
    end
  endtask

  task automatic rand_inputs(input int p_val, input int p_mrdy, input int p_rsp, input int p_rrdy);
    for (int i = 0; i < N; i++) begin
      if (!req_val[i] && $urandom_range(99) < p_val) begin
        req_val[i]      = 1'b1;
        req_is_write[i] = $urandom_range(1);
        req_is_cas[i]   = ($urandom_range(3) == 0);
        req_addr[i]     = rnd64();
        req_data[i]     = rnd64();
        req_cas_exp[i]  = rnd64();
      end
      rsp_rdy[i] = ($urandom_range(99) < p_rrdy);
    end
    mem_req_rdy   = ($urandom_range(99) < p_mrdy);
    mem_resp_val  = ($urandom_range(99) < p_rsp);
    mem_resp_data = rnd64();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {56'd0, req_rdy, rsp_val, mem_req_val, mem_req_is_write},
        64'd0);
    chk({tag, "_ctl2"}, {62'd0, mem_req_is_cas, mem_resp_rdy}, 64'd0);
    chk({tag, "_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_data"}, mem_req_data, 64'd0);
    chk({tag, "_cas"}, mem_req_cas_exp, 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
  endtask

  initial begin
    req_val = '0; req_is_write = '1; req_is_cas = '1;
    req_addr = '1; req_data = '1; req_cas_exp = '1;
    rsp_rdy = '1; mem_req_rdy = 1'b1; mem_resp_val = 1'b1;
    mem_resp_data = 64'hFFFF_0000_1234_5678;
    req_val[1] = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk_outputs_zero("reset");
    req_val = '0; mem_resp_val = 1'b0; mem_req_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // directed single read from requester 0
    begin_cycle();
    req_val[0] = 1'b1; req_is_write[0] = 1'b0; req_is_cas[0] = 1'b0;
    req_addr[0] = 64'h100; mem_req_rdy = 1'b1;
    eval_cycle();
    chk("single_addr", mem_req_addr, 64'h100);
    begin_cycle();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 64'hDEAD; rsp_rdy = '1;
    eval_cycle();
    chk("single_rsp", {63'd0, rsp_val[0]}, 64'd1);
    begin_cycle();
    mem_resp_val = 1'b0;
    eval_cycle();
    chk("single_drained", 64'(tagq.size()), 64'd0);

    // randomized: fill-heavy, drain-heavy, mixed
    for (int c = 0; c < 300; c++) begin begin_cycle(); rand_inputs(60, 70, 10, 60); eval_cycle(); end
    for (int c = 0; c < 300; c++) begin begin_cycle(); rand_inputs(50, 50, 80, 80); eval_cycle(); end
    for (int c = 0; c < 300; c++) begin begin_cycle(); rand_inputs(40, 40, 40, 50); eval_cycle(); end

    // build up outstanding tags, then reset between clock edges
    for (int c = 0; c < 200 && tagq.size() < 2; c++) begin
      begin_cycle(); rand_inputs(90, 90, 0, 50); eval_cycle();
    end
    chk("fill_before_reset", 64'(tagq.size() >= 2), 64'd1);
    @(negedge clk);
    #2;
    req_val = '1; mem_req_rdy = 1'b1; mem_resp_val = 1'b1; rsp_rdy = '1;
    mem_resp_data = rnd64();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midop_reset");
    model_reset();
    req_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    begin_cycle();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; rsp_rdy = '1;
    eval_cycle();
    chk("post_reset_resp_rdy", 64'(mem_resp_rdy), 64'd0);

    for (int c = 0; c < 200; c++) begin begin_cycle(); rand_inputs(50, 60, 50, 60); eval_cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
